fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS datapath, sitting directly upstream and downstream of the program ROM. It holds the program counter and drives the ROM's byte address. It receives the combinationally read instruction word and registers it, with PC+4, into the IF/ID pipeline register. It handles stall, flush, branch/jump redirect, a one-cycle boot state, and optional halt detection.

---
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the program ROM, registers {instr, PC+4, valid} into IF/ID.
// Latency: one edge from PCAddress to IF/ID; one BOOT cycle after reset release; redirect costs one bubble.
// Backpressure: Stall freezes PC and IF/ID; Flush/Redirect insert a bubble. Optional halt: FETCH_HALT_EN.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectAddress,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PCAddress,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PC4,
    output logic                  IFID_Valid,
    output logic                  Halted
);

    // HALTED is only reachable when halt detection is compiled in.
    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1
`ifdef FETCH_HALT_EN
        ,
        ST_HALTED  = 2'd2
`endif
    } state_t;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   ifid_ins_q, ifid_ins_d;
    logic [DATA_WIDTH-1:0]   ifid_pc4_q, ifid_pc4_d;
    logic                    ifid_vld_q, ifid_vld_d;

    // Sequential PC increment; wraps naturally at the top of the address space.
    logic [DATA_WIDTH-1:0]   pc_plus4;
    // Redirect targets are forced to word alignment; the low two bits are dropped.
    logic [DATA_WIDTH-1:0]   redirect_pc;
    logic                    unused_redirect_lsbs;

    assign pc_plus4             = pc_q + PC_STEP;
    assign redirect_pc          = {RedirectAddress[DATA_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^RedirectAddress[1:0];

`ifdef FETCH_HALT_EN
    logic halt_hit;
    assign halt_hit = (Instruction == HALT_WORD);
`else
    // Without halt detection the halt encoding is just another instruction.
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
`endif

    // Next-state / next-PC / next-IF/ID selection; priority Redirect > Stall(+Flush) > Flush > (halt) > fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_ins_d = ifid_ins_q;
        ifid_pc4_d = ifid_pc4_q;
        ifid_vld_d = ifid_vld_q;

        case (state_q)
            ST_BOOT: begin
                // One settling cycle: ROM output at RESET_PC is not captured yet.
                state_d    = ST_RUN;
                ifid_ins_d = NOP_WORD;
                ifid_pc4_d = '0;
                ifid_vld_d = 1'b0;
            end

            ST_RUN: begin
                if (Redirect) begin
                    // Taken branch/jump wins even over a stall so the target is never lost.
                    pc_d       = redirect_pc;
                    ifid_ins_d = NOP_WORD;
                    ifid_pc4_d = '0;
                    ifid_vld_d = 1'b0;
                end else if (Stall && Flush) begin
                    pc_d       = pc_q;
                    ifid_ins_d = NOP_WORD;
                    ifid_pc4_d = '0;
                    ifid_vld_d = 1'b0;
                end else if (Stall) begin
                    pc_d       = pc_q;
                end else if (Flush) begin
                    pc_d       = pc_plus4;
                    ifid_ins_d = NOP_WORD;
                    ifid_pc4_d = '0;
                    ifid_vld_d = 1'b0;
`ifdef FETCH_HALT_EN
                end else if (halt_hit) begin
                    // The halt word itself is never issued downstream.
                    state_d    = ST_HALTED;
                    pc_d       = pc_q;
                    ifid_ins_d = NOP_WORD;
                    ifid_pc4_d = '0;
                    ifid_vld_d = 1'b0;
`endif
                end else begin
                    pc_d       = pc_plus4;
                    ifid_ins_d = Instruction;
                    ifid_pc4_d = pc_plus4;
                    ifid_vld_d = 1'b1;
                end
            end

`ifdef FETCH_HALT_EN
            ST_HALTED: begin
                // Terminal until reset; all hazard/redirect inputs are ignored.
                state_d    = ST_HALTED;
                pc_d       = pc_q;
                ifid_ins_d = NOP_WORD;
                ifid_pc4_d = '0;
                ifid_vld_d = 1'b0;
            end
`endif

            default: begin
                // Unreachable encodings recover through BOOT with a clean bubble.
                state_d    = ST_BOOT;
                pc_d       = RESET_PC;
                ifid_ins_d = NOP_WORD;
                ifid_pc4_d = '0;
                ifid_vld_d = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers; reset clears everything asynchronously, including any pending redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            ifid_ins_q <= NOP_WORD;
            ifid_pc4_q <= '0;
            ifid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifid_ins_q <= ifid_ins_d;
            ifid_pc4_q <= ifid_pc4_d;
            ifid_vld_q <= ifid_vld_d;
        end
    end

    assign PCAddress        = pc_q;
    assign IFID_Instruction = ifid_ins_q;
    assign IFID_PC4         = ifid_pc4_q;
    assign IFID_Valid       = ifid_vld_q;

`ifdef FETCH_HALT_EN
    // Decoded straight from the state flop, so it is a registered signal.
    assign Halted = (state_q == ST_HALTED);
`else
    assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for reset/halt, and randomized run vs a reference model.
// Works with or without FETCH_HALT_EN; the model follows the same build switch.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectAddress = 32'h0;
    logic [31:0] Instruction;
    logic [31:0] PCAddress;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PC4;
    logic        IFID_Valid;
    logic        Halted;

    logic [31:0] halt_addr = 32'h0;
    logic        halt_on   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .Redirect         (Redirect),
        .RedirectAddress  (RedirectAddress),
        .Instruction      (Instruction),
        .PCAddress        (PCAddress),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC4         (IFID_PC4),
        .IFID_Valid       (IFID_Valid),
        .Halted           (Halted)
    );

    always #5 clk = ~clk;

    // Program ROM contents: two fixed words, an optional halt word, hashed filler elsewhere.
    function automatic logic [31:0] rom_word(input logic [31:0] a, input logic [31:0] ha, input logic hon);
        logic [31:0] w;
        if (hon && a == ha) return HALTW;
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h2009_0003;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        if (w == HALTW) w = 32'h1234_5678;
        return w;
    endfunction

    assign Instruction = rom_word(PCAddress, halt_addr, halt_on);

    // Reference model state.
    logic        m_boot, m_halt, m_vld;
    logic [31:0] m_pc, m_ins, m_pc4;

    task automatic model_reset();
        m_boot = 1'b1; m_halt = 1'b0; m_pc = 32'h0;
        m_ins = NOP; m_pc4 = 32'h0; m_vld = 1'b0;
    endtask

    task automatic model_bubble();
        m_ins = NOP; m_pc4 = 32'h0; m_vld = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic rd,
                              input logic [31:0] ra, input logic [31:0] ins);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            model_bubble();
        end else if (rd) begin
            m_pc = ra & ~32'h3;
            model_bubble();
        end else if (st && fl) begin
            model_bubble();
        end else if (st) begin
            // hold
        end else if (fl) begin
            m_pc = m_pc + 32'd4;
            model_bubble();
`ifdef FETCH_HALT_EN
        end else if (ins == HALTW) begin
            m_halt = 1'b1;
            model_bubble();
`endif
        end else begin
            m_ins = ins;
            m_pc4 = m_pc + 32'd4;
            m_vld = 1'b1;
            m_pc  = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},   PCAddress,           m_pc);
        chk({tag, ".ins"},  IFID_Instruction,    m_ins);
        chk({tag, ".pc4"},  IFID_PC4,            m_pc4);
        chk({tag, ".vld"},  32'(IFID_Valid),     32'(m_vld));
        chk({tag, ".halt"}, 32'(Halted),         32'(m_halt));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".pc"},   PCAddress,        32'h0);
        chk({tag, ".ins"},  IFID_Instruction, NOP);
        chk({tag, ".pc4"},  IFID_PC4,         32'h0);
        chk({tag, ".vld"},  32'(IFID_Valid),  32'h0);
        chk({tag, ".halt"}, 32'(Halted),      32'h0);
    endtask

    // Drive one cycle of inputs shortly after an edge, advance the model on the next edge, settle, return.
    task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] ra);
        logic [31:0] ins;
        Stall = st; Flush = fl; Redirect = rd; RedirectAddress = ra;
        ins = rom_word(m_pc, halt_addr, halt_on);
        @(posedge clk);
        model_edge(st, fl, rd, ra, ins);
        #1;
    endtask

    // Assert reset between edges, check it took effect without a clock, release mid-cycle.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_values(tag);
        @(posedge clk);
        #3;
        Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0;
        reset = 1'b1;
    endtask

    typedef struct {
        logic        st, fl, rd;
        logic [31:0] ra;
        logic [31:0] e_pc, e_ins, e_pc4;
        logic        e_vld;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: boot, first fetches, stall, redirect, wrap, flush, stall+flush.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h40,       32'h0,        NOP,                          32'h0,  1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h2008_0005,                32'h4,  1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h2009_0003,                32'h8,  1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h2009_0003,                32'h8,  1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h2009_0003,                32'h8,  1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        rom_word(32'h8, 0, 0),        32'hC,  1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h23,       32'h20,       NOP,                          32'h0,  1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h24,       rom_word(32'h20, 0, 0),       32'h24, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFC, NOP,                          32'h0,  1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        rom_word(32'hFFFFFFFC, 0, 0), 32'h0,  1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h4,        NOP,                          32'h0,  1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,        32'h4,        NOP,                          32'h0,  1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h2009_0003,                32'h8,  1'b1};

        #3;
        do_reset("rst0");
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].st, tbl[i].fl, tbl[i].rd, tbl[i].ra);
            chk($sformatf("tbl%0d.pc", i),   PCAddress,          tbl[i].e_pc);
            chk($sformatf("tbl%0d.ins", i),  IFID_Instruction,   tbl[i].e_ins);
            chk($sformatf("tbl%0d.pc4", i),  IFID_PC4,           tbl[i].e_pc4);
            chk($sformatf("tbl%0d.vld", i),  32'(IFID_Valid),    32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d.halt", i), 32'(Halted),        32'h0);
        end

        // Async reset mid-stream with a redirect pending; BOOT must then ignore the redirect.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        Redirect = 1'b1; RedirectAddress = 32'h100;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("arst");
        @(posedge clk);
        #1;
        check_reset_values("arst_hold");
        #2;
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h100);
        chk("arst_boot.pc",  PCAddress,       32'h0);
        chk("arst_boot.vld", 32'(IFID_Valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("arst_first.pc",  PCAddress,        32'h4);
        chk("arst_first.ins", IFID_Instruction, 32'h2008_0005);
        chk("arst_first.vld", 32'(IFID_Valid),  32'h1);

        // Halt word at address 8.
        halt_addr = 32'h8; halt_on = 1'b1;
        do_reset("rst_h");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            check_model($sformatf("halt_run%0d", i));
        end
`ifdef FETCH_HALT_EN
        chk("halt.halted", 32'(Halted),      32'h1);
        chk("halt.pc",     PCAddress,        32'h8);
        chk("halt.vld",    32'(IFID_Valid),  32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h40);
        chk("halt_rd.pc",     PCAddress,       32'h8);
        chk("halt_rd.halted", 32'(Halted),     32'h1);
        chk("halt_rd.vld",    32'(IFID_Valid), 32'h0);
`else
        chk("nohalt.halted", 32'(Halted),        32'h0);
        chk("nohalt.ins",    IFID_Instruction,   HALTW);
        chk("nohalt.pc",     PCAddress,          32'hC);
        chk("nohalt.vld",    32'(IFID_Valid),    32'h1);
`endif
        do_reset("halt_rst");

        // Randomized run against the model, with periodic resets and a halt word in the path.
        halt_addr = 32'h30;
        for (int i = 0; i < 600; i++) begin
            logic        st, fl, rd;
            logic [31:0] ra;
            if (i % 75 == 74) begin
                do_reset($sformatf("rnd_rst%0d", i));
            end else begin
                rd = ($urandom_range(0, 7) == 0);
                st = ($urandom_range(0, 3) == 0);
                fl = ($urandom_range(0, 5) == 0);
                case ($urandom_range(0, 3))
                    0:       ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    1:       ra = 32'($urandom_range(0, 127));
                    default: ra = $urandom;
                endcase
                step(st, fl, rd, ra);
                check_model($sformatf("rnd%0d", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
